// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue between the PC/ROM fetch path and the IF/ID stage.
// Small circular FIFO of {pc, inst} pairs, flushed on a taken branch.
module inst_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [5:0]               stall,
   input  logic                     branch_flag_i,
   input  logic                     fetch_valid_i,
   input  logic [AW-1:0]            fetch_pc_i,
   input  logic [DW-1:0]            fetch_inst_i,
   output logic                     fetch_hold_o,
   output logic                     id_valid_o,
   output logic [AW-1:0]            id_pc_o,
   output logic [DW-1:0]            id_inst_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = AW + DW;

   // Handshake: a pair is taken on an edge where fetch_valid_i=1 and
   // fetch_hold_o=0; while hold is high upstream keeps re-presenting the same
   // pair. Decode takes the head on an edge where id_valid_o=1 and stall[1]=0.
   // A taken branch cancels both transfers in that cycle.

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic unused_stall;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   assign push = fetch_valid_i & ~full & ~branch_flag_i;
   assign pop  = ~empty & ~stall[1] & ~branch_flag_i;

   assign unused_stall = ^{stall[5:2], stall[0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (branch_flag_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   // Storage is deliberately not reset or cleared on flush; count gates validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {fetch_pc_i, fetch_inst_i};
      end
   end

   logic [EW-1:0] head;
   assign head = mem[rd_ptr];

   assign fetch_hold_o = full;
   assign id_valid_o   = ~empty;
   assign id_pc_o      = empty ? '0 : head[EW-1:DW];
   assign id_inst_o    = empty ? '0 : head[DW-1:0];
   assign level_o      = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based
// reference model of the prefetch FIFO.
module tb_inst_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic          clk;
   logic          rst;
   logic [5:0]    stall;
   logic          branch_flag;
   logic          fetch_valid;
   logic [AW-1:0] fetch_pc;
   logic [DW-1:0] fetch_inst;
   logic          fetch_hold;
   logic          id_valid;
   logic [AW-1:0] id_pc;
   logic [DW-1:0] id_inst;
   logic [2:0]    level;

   inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_flag_i (branch_flag),
      .fetch_valid_i (fetch_valid),
      .fetch_pc_i    (fetch_pc),
      .fetch_inst_i  (fetch_inst),
      .fetch_hold_o  (fetch_hold),
      .id_valid_o    (id_valid),
      .id_pc_o       (id_pc),
      .id_inst_o     (id_inst),
      .level_o       (level)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   logic [AW+DW-1:0] exp_q[$];
   logic [AW-1:0]    cur_pc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_outputs();
      logic [AW+DW-1:0] h;
      h = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
      check("id_pc",    64'(id_pc),    64'(h[AW+DW-1:DW]));
      check("id_inst",  64'(id_inst),  64'(h[DW-1:0]));
      check("level",    64'(level),    64'(exp_q.size()));
      check("hold",     64'(fetch_hold), 64'(exp_q.size() == DEPTH));
   endtask

   // One cycle: drive at the falling edge, update model at the rising edge,
   // check outputs at the next falling edge.
   task automatic step(input logic [5:0] st, input bit br, input bit fv, input logic [AW-1:0] target);
      bit do_push;
      bit do_pop;
      stall       = st;
      branch_flag = br;
      fetch_valid = fv;
      fetch_pc    = cur_pc;
      fetch_inst  = cur_pc + 32'h1000;
      @(posedge clk);
      do_push = 1'b0;
      if (br) begin
         exp_q.delete();
         cur_pc = target;
      end else begin
         do_pop  = (exp_q.size() != 0) && !st[1];
         do_push = fv && (exp_q.size() < DEPTH);
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            exp_q.push_back({cur_pc, cur_pc + 32'h1000});
            cur_pc = cur_pc + 32'd4;
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst         = 1'b0;
      stall       = '0;
      branch_flag = 1'b0;
      fetch_valid = 1'b0;
      fetch_pc    = '0;
      fetch_inst  = '0;
      cur_pc      = '0;

      // reset state while asserted
      repeat (3) @(negedge clk);
      check_outputs();
      rst = 1'b1;

      // idle after release
      repeat (5) step(6'h00, 1'b0, 1'b0, '0);

      // streaming with no stall: level settles at 1
      repeat (8) step(6'h00, 1'b0, 1'b1, '0);
      check("stream_level", 64'(level), 64'd1);

      // flush back to pc 0, then fill while decode is stalled
      step(6'h00, 1'b1, 1'b0, 32'h0);
      repeat (4) step(6'h02, 1'b0, 1'b1, '0);
      check("fill_hold", 64'(fetch_hold), 64'd1);
      repeat (3) step(6'h02, 1'b0, 1'b1, '0);
      check("rejected_pc", 64'(cur_pc), 64'h10);

      // release stall while full: pop plus rejected push
      step(6'h00, 1'b0, 1'b1, '0);
      check("drain_level", 64'(level), 64'd3);
      repeat (12) step(6'h00, 1'b0, 1'b1, '0);

      // build level 3, then flush while 0x40 is presented
      step(6'h00, 1'b1, 1'b0, 32'h0);
      repeat (3) step(6'h02, 1'b0, 1'b1, '0);
      cur_pc = 32'h40;
      step(6'h00, 1'b1, 1'b1, 32'h80);
      check("flush_valid", 64'(id_valid), 64'd0);
      step(6'h02, 1'b0, 1'b1, '0);
      check("post_flush_pc", 64'(id_pc), 64'h80);

      // asynchronous reset between edges with level 2
      step(6'h00, 1'b1, 1'b0, 32'h100);
      repeat (2) step(6'h02, 1'b0, 1'b1, '0);
      #2 rst = 1'b0;
      #1;
      exp_q.delete();
      cur_pc = '0;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;
      repeat (4) step(6'h00, 1'b0, 1'b1, '0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [5:0] st;
         bit br;
         bit fv;
         st = 6'($urandom_range(0, 63));
         br = ($urandom_range(0, 15) == 0);
         fv = ($urandom_range(0, 3) != 0);
         step(st, br, fv, 32'($urandom_range(0, 1023)) << 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction prefetch queue between `pc_reg` plus the instruction ROM and the IF/ID stage. Each cycle it captures the fetched `{pc, inst}` pair into a small circular FIFO and presents the oldest entry to decode. It keeps fetching while decode is stalled and tells `pc_reg` to hold when the queue is full. A taken branch flushes every queued entry.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `AW`, 32: instruction address width.
- `DW`, 32: instruction word width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `stall`  in  6  pipeline stall vector from ctrl. `stall[1]`=1 means ID is stalled and must not consume.
- `branch_flag_i`  in  1  taken-branch flush, same signal that drives `pc_reg`.
- `fetch_valid_i`  in  1  `fetch_pc_i`/`fetch_inst_i` are valid this cycle (ROM enabled).
- `fetch_pc_i`  in  AW  address of the fetched instruction.
- `fetch_inst_i`  in  DW  instruction word from the ROM.
- `fetch_hold_o`  out  1  queue is full; upstream must hold the PC and re-present the same pair.
- `id_valid_o`  out  1  the head entry is valid.
- `id_pc_o`  out  AW  head PC; 0 when empty.
- `id_inst_o`  out  DW  head instruction; 0 (NOP) when empty.
- `level_o`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH×(AW+DW) register array, `wr_ptr` and `rd_ptr` of log2(DEPTH) bits, and `count` of log2(DEPTH)+1 bits.
- Pointers wrap naturally modulo DEPTH. There is no extra wrap bit; `count` alone distinguishes full from empty.
- Derived flags:
  - `empty` = (count==0).
  - `full` = (count==DEPTH).
  - `fetch_hold_o` = `full`.
  - `id_valid_o` = !`empty`.
  - `level_o` = `count`.
- Control terms:
  - push = `fetch_valid_i` & !`full` & !`branch_flag_i`.
  - pop = `id_valid_o` & (`stall[1]`==0) & !`branch_flag_i`.
- Push: write `{fetch_pc_i, fetch_inst_i}` at `wr_ptr`, then `wr_ptr`+1.
- Pop: `rd_ptr`+1.
- `count` update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- While full, `fetch_valid_i` is ignored (no push). The upstream PC hold guarantees the same pair is re-presented, so nothing is lost.
- Flush (`branch_flag_i`=1) has priority over push and pop.
  - Next edge: `wr_ptr`=`rd_ptr`=0, `count`=0.
  - The pair presented in the flush cycle (delay-slot fetch path) is discarded.
  - Array contents are not cleared.
- Head outputs are driven from `array[rd_ptr]` when not empty, otherwise forced to 0. They are combinational from registered state only, with no path from any input.
- No state machine beyond the counters. The queue states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), all implied by `count`.

## Timing
- Reset (rst=0, asynchronous): `wr_ptr`=`rd_ptr`=0 and `count`=0, giving `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=0, `fetch_hold_o`=0, `level_o`=0.
- A reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Push-to-head latency is 1 cycle: a pair pushed at edge N is visible at the outputs after edge N when the queue was empty.
- Pop takes effect at the edge; the next entry appears after that edge.
- `fetch_hold_o` rises in the cycle after the push that filled the queue. It falls in the cycle after the first pop from full.
- Simultaneous push and pop at an intermediate level: `count` is unchanged and pointers advance together.
- When full with a pop: the push is rejected, `count`→DEPTH−1, and hold drops the next cycle.
- When empty: pop is impossible; a push is accepted.
- Flush together with push and/or pop: the queue becomes empty after the edge and `id_valid_o`=0 the next cycle.
- Pointer wrap: after DEPTH pushes `wr_ptr` returns to 0. Ordering is strictly FIFO across the wrap.

## Test plan
- Reset/empty: hold `rst`=0, then release with `fetch_valid_i`=0 → all outputs 0 and `level_o`=0 for 5 cycles.
- Stream, no stall: push pc 0x0,0x4,0x8,… with inst=pc+0x1000 every cycle, `stall`=0 → `id_pc_o` follows 1 cycle behind, `level_o` stays at 1, `fetch_hold_o` never asserts.
- Fill: set `stall[1]`=1 and push 0x0..0xC → `level_o`=4 and `fetch_hold_o`=1. Present 0x10 for 3 cycles → it is not stored.
- Drain from full:
  - Release `stall[1]` while 0x10 is presented → pop plus rejected push, so `level_o`=3 and hold falls.
  - Next edge accepts 0x10.
  - Output order is 0x0,0x4,0x8,0xC,0x10.
  - Continue the stream to 0x20 → wrap-around preserves order.
- Flush: with `level_o`=3, pulse `branch_flag_i` while pushing 0x40 → the next cycle has `level_o`=0 and `id_valid_o`=0. The following push of 0x80 appears at the head 1 cycle later.
- Async reset mid-stream: drive `rst`=0 between edges with `level_o`=2 → outputs go to 0 before the next edge. After release, operation resumes from empty.
